// File: rtl/loop_issue_if.sv
// Start/issue handshake bundle for loop_issue_ctrl.
// Stats ports exist only when LOOP_ISSUE_STATS_EN is defined.
interface loop_issue_if #(
  parameter int TW  = 16,
  parameter int IIW = 8
);
  logic           start;
  logic           start_ready;
  logic [IIW-1:0] ii_in;
  logic [TW-1:0]  trip_in;
  logic           stall;
  logic           issue_valid;
  logic [TW-1:0]  iter_idx;
  logic           last_iter;
  logic           busy;
  logic           done;
`ifdef LOOP_ISSUE_STATS_EN
  logic [31:0]    stat_cycles;
  logic [31:0]    stat_stalls;

  modport master (
    output start, ii_in, trip_in, stall,
    input  start_ready, issue_valid, iter_idx,
    input  last_iter, busy, done,
    input  stat_cycles, stat_stalls
  );
  modport slave (
    input  start, ii_in, trip_in, stall,
    output start_ready, issue_valid, iter_idx,
    output last_iter, busy, done,
    output stat_cycles, stat_stalls
  );
`else
  modport master (
    output start, ii_in, trip_in, stall,
    input  start_ready, issue_valid, iter_idx,
    input  last_iter, busy, done
  );
  modport slave (
    input  start, ii_in, trip_in, stall,
    output start_ready, issue_valid, iter_idx,
    output last_iter, busy, done
  );
`endif
endinterface

// File: rtl/loop_issue_ctrl.sv
// Loop issue controller: one issue pulse every II unstalled cycles, then drain.
// Optional cycle/stall statistics under LOOP_ISSUE_STATS_EN.
module loop_issue_ctrl #(
  parameter int TW    = 16,
  parameter int IIW   = 8,
  parameter int DEPTH = 2
) (
  input logic        clk,
  input logic        rst,
  loop_issue_if.slave bus
);
  localparam int DW = (DEPTH > 0) ? $clog2(DEPTH + 1) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t         state, state_n;
  logic [IIW-1:0] ii_q, ii_n;
  logic [IIW-1:0] ii_cnt, ii_cnt_n;
  logic [TW-1:0]  trip_q, trip_n;
  logic [TW-1:0]  idx, idx_n;
  logic [DW-1:0]  dcnt, dcnt_n;
  logic           accept;
  logic           issue;
  logic           last;
  logic           fin;

  assign accept = bus.start & (state == IDLE);
  assign issue  = (state == ISSUE) & (ii_cnt == '0) & ~bus.stall;
  assign last   = issue & (idx == trip_q - TW'(1));
  assign fin    = (state == DRAIN) & (dcnt == '0);

  assign bus.start_ready = (state == IDLE);
  assign bus.busy        = (state != IDLE);
  assign bus.issue_valid = issue;
  assign bus.last_iter   = last;
  assign bus.done        = fin;
  assign bus.iter_idx    = idx;

  always_comb begin
    state_n  = state;
    ii_n     = ii_q;
    ii_cnt_n = ii_cnt;
    trip_n   = trip_q;
    idx_n    = idx;
    dcnt_n   = dcnt;
    unique case (1'b1)
      state == IDLE: begin
        if (accept) begin
          if (bus.trip_in != '0) begin
            state_n  = ISSUE;
            ii_n     = (bus.ii_in == '0) ? IIW'(1) : bus.ii_in;
            trip_n   = bus.trip_in;
            idx_n    = '0;
            ii_cnt_n = '0;
          end else begin
            state_n = DRAIN;
            dcnt_n  = '0;
          end
        end
      end
      state == ISSUE: begin
        if (issue) begin
          ii_cnt_n = ii_q - IIW'(1);
          // idx parks on trip-1 so iter_idx keeps the last issued index
          if (last) begin
            state_n = DRAIN;
            dcnt_n  = DW'(DEPTH);
          end else begin
            idx_n = idx + TW'(1);
          end
        end else if (!bus.stall && ii_cnt != '0) begin
          ii_cnt_n = ii_cnt - IIW'(1);
        end
      end
      state == DRAIN: begin
        if (fin) begin
          state_n = IDLE;
        end else if (!bus.stall) begin
          dcnt_n = dcnt - DW'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      ii_q   <= '0;
      ii_cnt <= '0;
      trip_q <= '0;
      idx    <= '0;
      dcnt   <= '0;
    end else begin
      state  <= state_n;
      ii_q   <= ii_n;
      ii_cnt <= ii_cnt_n;
      trip_q <= trip_n;
      idx    <= idx_n;
      dcnt   <= dcnt_n;
    end
  end

`ifdef LOOP_ISSUE_STATS_EN
  logic [31:0] cyc_q;
  logic [31:0] stl_q;

  always_ff @(posedge clk) begin
    if (rst || accept) begin
      cyc_q <= '0;
      stl_q <= '0;
    end else if (state != IDLE) begin
      if (cyc_q != '1) cyc_q <= cyc_q + 32'd1;
      if (bus.stall && stl_q != '1) stl_q <= stl_q + 32'd1;
    end
  end

  assign bus.stat_cycles = cyc_q;
  assign bus.stat_stalls = stl_q;
`endif
endmodule

// File: tb/tb_loop_issue_ctrl.sv
// Bench for loop_issue_ctrl: DEPTH=2/TW=16 and DEPTH=0/TW=4 instances side by side.
module tb_loop_issue_ctrl;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  loop_issue_if #(.TW(16), .IIW(8)) bus0 ();
  loop_issue_if #(.TW(4),  .IIW(3)) bus1 ();

  loop_issue_ctrl #(.TW(16), .IIW(8), .DEPTH(2)) u0 (
    .clk(clk), .rst(rst), .bus(bus0)
  );
  loop_issue_ctrl #(.TW(4), .IIW(3), .DEPTH(0)) u1 (
    .clk(clk), .rst(rst), .bus(bus1)
  );

  typedef struct {
    int          ii;
    int          trip;
    int          s_lo;
    int          s_hi;
    int          start2;
    logic [31:0] mask;
    int          done2;
    int          done0;
  } scn_t;

  scn_t tbl [10];
  int   errors = 0;
  int   checks = 0;

  int          cnt    [2];
  int          donec  [2];
  int          ndone  [2];
  int          idxerr [2];
  int          rdy    [2];
  logic [31:0] mask   [2];

  // reference model state
  int depth [2] = '{2, 0};
  int act [2], ph [2], issued [2], since [2];
  int drained [2], need [2], mtrip [2], mii [2], held [2];

  task automatic chk(string name, longint got, longint exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(logic st, int ii, int trip, logic stl);
    bus0.start   = st;
    bus1.start   = st;
    bus0.ii_in   = 8'(ii);
    bus1.ii_in   = 3'(ii);
    bus0.trip_in = 16'(trip);
    bus1.trip_in = 4'(trip);
    bus0.stall   = stl;
    bus1.stall   = stl;
  endtask

  task automatic rec(int k, int c, int trip, logic iv, int idx,
                     logic li, logic dn, logic sr);
    if (iv) begin
      mask[k] |= 32'(1) << c;
      if (idx != cnt[k] || li != (cnt[k] == trip - 1)) idxerr[k]++;
      cnt[k]++;
    end else if (li) begin
      idxerr[k]++;
    end
    if (dn) begin
      ndone[k]++;
      if (donec[k] < 0) donec[k] = c;
    end
    if (donec[k] >= 0 && c == donec[k] + 1) rdy[k] = sr;
  endtask

  task automatic run_scn(int n, scn_t s);
    int  dexp [2];
    int  nst;
    logic stl;
    dexp[0] = s.done2;
    dexp[1] = s.done0;
    for (int k = 0; k < 2; k++) begin
      cnt[k] = 0; donec[k] = -1; ndone[k] = 0;
      idxerr[k] = 0; rdy[k] = 0; mask[k] = '0;
    end
    for (int c = 0; c < 24; c++) begin
      stl = (c >= s.s_lo && c <= s.s_hi);
      drive((c == 0) || (c == s.start2), s.ii, s.trip, stl);
      #2;
      rec(0, c, s.trip, bus0.issue_valid, int'(bus0.iter_idx),
          bus0.last_iter, bus0.done, bus0.start_ready);
      rec(1, c, s.trip, bus1.issue_valid, int'(bus1.iter_idx),
          bus1.last_iter, bus1.done, bus1.start_ready);
      tick();
    end
    drive(1'b0, 0, 0, 1'b0);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("scn%0d_d%0d_issue_mask", n, depth[k]),
          mask[k], s.mask);
      chk($sformatf("scn%0d_d%0d_idx_last", n, depth[k]), idxerr[k], 0);
      chk($sformatf("scn%0d_d%0d_done_cycle", n, depth[k]),
          donec[k], dexp[k]);
      chk($sformatf("scn%0d_d%0d_done_count", n, depth[k]), ndone[k], 1);
      chk($sformatf("scn%0d_d%0d_ready_after", n, depth[k]), rdy[k], 1);
    end
`ifdef LOOP_ISSUE_STATS_EN
    for (int k = 0; k < 2; k++) begin
      nst = 0;
      for (int c = 1; c <= dexp[k]; c++)
        if (c >= s.s_lo && c <= s.s_hi) nst++;
      chk($sformatf("scn%0d_d%0d_stat_cycles", n, depth[k]),
          (k == 0) ? bus0.stat_cycles : bus1.stat_cycles, dexp[k]);
      chk($sformatf("scn%0d_d%0d_stat_stalls", n, depth[k]),
          (k == 0) ? bus0.stat_stalls : bus1.stat_stalls, nst);
    end
`else
    nst = 0;
`endif
  endtask

  function automatic longint model_out(int k, logic stl);
    logic sr, bu, iv, li, dn;
    int   idx;
    sr  = (act[k] == 0);
    bu  = (act[k] != 0);
    iv  = bu && ph[k] == 1 && !stl && since[k] >= mii[k] - 1;
    li  = iv && issued[k] == mtrip[k] - 1;
    dn  = bu && ph[k] == 2 && drained[k] >= need[k];
    idx = (bu && ph[k] == 1) ? issued[k] : held[k];
    return {sr, bu, iv, li, dn, 16'(idx)};
  endfunction

  task automatic model_step(int k, logic r, logic st, int ii,
                            int trip, logic stl);
    longint o;
    o = model_out(k, stl);
    if (r) begin
      act[k] = 0;
      held[k] = 0;
    end else if (act[k] == 0) begin
      if (st) begin
        act[k]   = 1;
        mii[k]   = (ii == 0) ? 1 : ii;
        mtrip[k] = trip;
        if (trip > 0) begin
          ph[k] = 1; issued[k] = 0; since[k] = mii[k] - 1;
        end else begin
          ph[k] = 2; drained[k] = 0; need[k] = 0;
        end
      end
    end else if (ph[k] == 1) begin
      if (o[18]) begin
        held[k] = issued[k];
        issued[k]++;
        since[k] = 0;
        if (issued[k] == mtrip[k]) begin
          ph[k] = 2; drained[k] = 0; need[k] = depth[k];
        end
      end else if (!stl) begin
        since[k]++;
      end
    end else begin
      if (o[16]) act[k] = 0;
      else if (!stl) drained[k]++;
    end
  endtask

  initial begin
    int n;
    logic r, st, stl;
    int ii, trip;
    longint got0, got1;

    tbl[0] = '{3, 4,  -1, -1, -1, 32'h492,  13, 11};
    tbl[1] = '{1, 3,  -1, -1, -1, 32'hE,     6,  4};
    tbl[2] = '{0, 3,  -1, -1, -1, 32'hE,     6,  4};
    tbl[3] = '{2, 2,   2,  3, -1, 32'h22,    8,  6};
    tbl[4] = '{5, 0,  -1, -1, -1, 32'h0,     1,  1};
    tbl[5] = '{3, 4,  -1, -1,  5, 32'h492,  13, 11};
    tbl[6] = '{1, 1,   2,  3, -1, 32'h2,     6,  2};
    tbl[7] = '{2, 2,   1,  1, -1, 32'h14,    7,  5};
    tbl[8] = '{1, 15, -1, -1, -1, 32'hFFFE, 18, 16};
    tbl[9] = '{1, 2,  -1, -1, -1, 32'h6,     5,  3};

    rst = 1'b1;
    drive(1'b0, 0, 0, 1'b0);
    tick();
    tick();
    rst = 1'b0;
    #2;
    chk("rst_start_ready", bus0.start_ready, 1);
    chk("rst_busy",        bus0.busy,        0);
    chk("rst_issue_valid", bus0.issue_valid, 0);
    chk("rst_done",        bus0.done,        0);
    chk("rst_iter_idx",    bus0.iter_idx,    0);
    chk("rst_d0_ready",    bus1.start_ready, 1);
    tick();

    for (int i = 0; i < 9; i++) run_scn(i, tbl[i]);

    // abort a running loop with reset at cycle 5
    drive(1'b1, 3, 4, 1'b0);
    tick();
    drive(1'b0, 3, 4, 1'b0);
    for (int c = 1; c < 5; c++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #2;
    chk("abort_busy",  {bus0.busy, bus1.busy}, 0);
    chk("abort_ready", {bus0.start_ready, bus1.start_ready}, 3);
    chk("abort_idx",   bus0.iter_idx, 0);
    tick();
    n = 0;
    for (int c = 0; c < 15; c++) begin
      #2;
      n += int'(bus0.issue_valid) + int'(bus1.issue_valid);
      n += int'(bus0.done) + int'(bus1.done);
      tick();
    end
    chk("abort_quiet", n, 0);
    run_scn(9, tbl[9]);

    // randomized run against the reference model
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int k = 0; k < 2; k++) begin
      act[k] = 0; ph[k] = 0; issued[k] = 0; since[k] = 0;
      drained[k] = 0; need[k] = 0; mtrip[k] = 0; mii[k] = 1; held[k] = 0;
    end
    for (int c = 0; c < 1500; c++) begin
      r    = ($urandom_range(63) == 0);
      st   = 1'($urandom_range(1));
      ii   = $urandom_range(4);
      trip = $urandom_range(6);
      stl  = ($urandom_range(3) == 0);
      drive(st, ii, trip, stl);
      rst = r;
      #2;
      got0 = {bus0.start_ready, bus0.busy, bus0.issue_valid,
              bus0.last_iter, bus0.done, bus0.iter_idx};
      got1 = {bus1.start_ready, bus1.busy, bus1.issue_valid,
              bus1.last_iter, bus1.done, 12'd0, bus1.iter_idx};
      chk($sformatf("rand_c%0d_d2", c), got0, model_out(0, stl));
      chk($sformatf("rand_c%0d_d0", c), got1, model_out(1, stl));
      model_step(0, r, st, ii, trip, stl);
      model_step(1, r, st, ii, trip, stl);
      tick();
    end
    rst = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
